fifo_rd_stream: RTL and testbench

//  Read-side controller for the AsyncFIFO read port (clkb domain).

---
 rtl/fifo_rd_pkg.sv | 29 ++
 rtl/fifo_rd_stream_if.sv | 31 +++
 rtl/fifo_rd_buf.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 136 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : fifo_rd_pkg
// State type and width helpers shared by the FIFO read-stream controller.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2
    } rd_state_t;

    localparam int C_DEF_BUF_D = 4;
    localparam int C_PTR_W     = $clog2(C_DEF_BUF_D) + 1;
    localparam int C_CRD_W     = $clog2(C_DEF_BUF_D + 1);

    // Extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptr_w(input int buf_d);
        return $clog2(buf_d) + 1;
    endfunction

    function automatic int crd_w(input int buf_d);
        return $clog2(buf_d + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : fifo_rd_stream_if
// FIFO read-port flags/data plus the downstream valid/ready stream.
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             empty;
    logic             almost_empty;
    logic [WIDTH-1:0] doutb;
    logic             enb;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CNT_W-1:0] rd_count;
    logic             ovf_err;

    modport master (
        input  empty, almost_empty, doutb, m_ready,
        output enb, m_valid, m_data, rd_count, ovf_err
    );

    modport slave (
        output empty, almost_empty, doutb, m_ready,
        input  enb, m_valid, m_data, rd_count, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fifo_rd_buf
// Small circular output buffer with push/pop, full/empty and occupancy.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int BUF_D = 4,
    localparam int PTR_W = ptr_w(BUF_D)
) (
    input  logic             clkb,
    input  logic             rstb,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = PTR_W - 1;

    logic [WIDTH-1:0] mem_q [BUF_D];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < BUF_D; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : fifo_rd_stream
// Pops an async FIFO read port under credit control and re-presents words as
// a valid/ready stream. Rev: 1.0
// ----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1,
    parameter int BUF_D  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clkb,
    input  logic             rstb,
    fifo_rd_stream_if.master bus
);
    localparam int PTR_W = ptr_w(BUF_D);
    localparam int CRD_W = crd_w(BUF_D);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [CNT_W-1:0]  rd_count_q;
    logic [CNT_W-1:0]  rd_count_d;
    logic              ovf_q;
    logic              ovf_d;

    logic [CRD_W-1:0]  w_in_flight;
    logic [CRD_W:0]    w_occ;
    logic              w_credit;
    logic              w_enb;
    logic              w_arrive;
    logic              w_hs;
    logic              w_full;
    logic              w_empty;
    logic [PTR_W-1:0]  w_count;
    logic [WIDTH-1:0]  w_head;

    // Latency tracker: bit i set means a pop issued i+1 edges ago.
    if (RD_LAT == 1) begin : g_lat1
        assign vld_d = w_enb;
    end else begin : g_latn
        assign vld_d = {vld_q[RD_LAT-2:0], w_enb};
    end

    assign w_arrive = vld_q[RD_LAT-1];

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_in_flight = w_in_flight + CRD_W'(vld_q[i]);
        end
    end

    assign w_occ    = (CRD_W+1)'(w_count) + (CRD_W+1)'(w_in_flight);
    assign w_credit = (w_occ < (CRD_W+1)'(BUF_D));

    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.almost_empty)  state_d = STREAM;
                else if (!bus.empty)    state_d = TAIL;
            end
            STREAM: begin
                if (bus.empty)             state_d = IDLE;
                else if (bus.almost_empty) state_d = TAIL;
            end
            TAIL: begin
                if (!bus.almost_empty)                      state_d = STREAM;
                else if (bus.empty && (w_in_flight == '0))  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // TAIL single-steps because the empty flag only catches up after a pop lands.
    always_comb begin
        w_enb = 1'b0;
        case (state_q)
            STREAM:  w_enb = w_credit;
            TAIL:    w_enb = !bus.empty && (w_in_flight == '0) && w_credit;
            default: w_enb = 1'b0;
        endcase
    end

    fifo_rd_buf #(
        .WIDTH (WIDTH),
        .BUF_D (BUF_D)
    ) u_buf (
        .clkb        (clkb),
        .rstb        (rstb),
        .push_i      (w_arrive),
        .push_data_i (bus.doutb),
        .pop_i       (w_hs),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count),
        .head_o      (w_head)
    );

    assign w_hs       = !w_empty && bus.m_ready;
    assign ovf_d      = ovf_q || (w_arrive && w_full);
    assign rd_count_d = rd_count_q + CNT_W'(w_hs);

    always_ff @(posedge clkb or negedge rstb) begin
        if (!rstb) begin
            vld_q      <= '0;
            rd_count_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            rd_count_q <= rd_count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.enb      = w_enb;
    assign bus.m_valid  = !w_empty;
    assign bus.m_data   = w_head;
    assign bus.rd_count = rd_count_q;
    assign bus.ovf_err  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_fifo_rd_stream
// Two configurations (RD_LAT=1/CNT_W=16 and RD_LAT=3/CNT_W=4) against a FIFO
// model and per-instance scoreboards. Rev: 1.0
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic        rstb_a [2];
    logic        mrdy_a [2];
    logic [7:0]  fmem   [2][256];
    int          wr_a   [2];
    logic [7:0]  sb     [2][$];

    logic        mv_w   [2];
    logic        enb_w  [2];
    logic        ovf_w  [2];
    logic [7:0]  md_w   [2];
    logic [15:0] rdc_w  [2];
    int          rd_w   [2];
    int          pops_w [2];

    int          dlv    [2] = '{0, 0};
    int          rc_exp [2] = '{0, 0};
    logic        hold_v [2] = '{1'b0, 1'b0};
    logic [7:0]  hold_d [2] = '{8'h00, 8'h00};
    bit          tail_mode  = 1'b0;
    int          last_pop   = -1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : 3;
        localparam int BD = (g == 0) ? 4 : 8;
        localparam int CW = (g == 0) ? 16 : 4;

        fifo_rd_stream_if #(.WIDTH(8), .CNT_W(CW)) bus ();

        fifo_rd_stream #(
            .WIDTH  (8),
            .RD_LAT (RL),
            .BUF_D  (BD),
            .CNT_W  (CW)
        ) dut (
            .clkb (clk),
            .rstb (rstb_a[g]),
            .bus  (bus)
        );

        int                 rd   = 0;
        int                 pops = 0;
        logic [RL-1:0][7:0] pipe;

        // FIFO model: flags track the true occupancy, data returns RL edges after a pop.
        assign bus.empty        = (wr_a[g] == rd);
        assign bus.almost_empty = ((wr_a[g] - rd) <= 3);
        assign bus.doutb        = pipe[RL-1];
        assign bus.m_ready      = mrdy_a[g];

        always @(posedge clk) begin
            if (bus.enb) begin
                check_eq("pop_nonempty", 32'(wr_a[g] != rd), 1);
                if (wr_a[g] != rd) rd <= rd + 1;
                pops <= pops + 1;
            end
            pipe[0] <= fmem[g][rd & 255];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        assign mv_w[g]   = bus.m_valid;
        assign enb_w[g]  = bus.enb;
        assign ovf_w[g]  = bus.ovf_err;
        assign md_w[g]   = bus.m_data;
        assign rdc_w[g]  = 16'(bus.rd_count);
        assign rd_w[g]   = rd;
        assign pops_w[g] = pops;
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rstb_a[g]) begin
                rc_exp[g] <= 0;
                hold_v[g] <= 1'b0;
            end else begin
                if (hold_v[g]) begin
                    check_eq("hold_valid", 32'(mv_w[g]), 1);
                    check_eq("hold_data", 32'(md_w[g]), 32'(hold_d[g]));
                end
                if (mv_w[g] && mrdy_a[g]) begin
                    check_eq("rd_count", 32'(rdc_w[g]), rc_exp[g] & ((g == 0) ? 32'hFFFF : 32'hF));
                    if (sb[g].size() == 0) check_eq("sb_size", sb[g].size(), 1);
                    else                   check_eq("data", 32'(md_w[g]), 32'(sb[g].pop_front()));
                    rc_exp[g] <= rc_exp[g] + 1;
                    dlv[g]    <= dlv[g] + 1;
                end
                hold_v[g] <= mv_w[g] && !mrdy_a[g];
                hold_d[g] <= md_w[g];
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!tail_mode) begin
            last_pop <= -1;
        end else if (enb_w[0]) begin
            if (last_pop >= 0) check_eq("tail_gap", 32'((cyc - last_pop) >= 2), 1);
            last_pop <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int g, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[g][wr_a[g] & 255] = base + 8'(i);
            sb[g].push_back(base + 8'(i));
            wr_a[g] = wr_a[g] + 1;
        end
    endtask

    task automatic wait_dlv(input int g, input int target, output int at);
        int n = 0;
        while (dlv[g] < target && n < 500) begin
            tick();
            n++;
        end
        at = cyc;
        check_eq("dlv_reached", 32'(dlv[g] >= target), 1);
    endtask

    task automatic wait_drain(input int g, input int bound);
        int n = 0;
        while ((sb[g].size() != 0 || mv_w[g]) && n < bound) begin
            tick();
            n++;
        end
        check_eq("drain_sb", sb[g].size(), 0);
        check_eq("drain_valid", 32'(mv_w[g]), 0);
    endtask

    task automatic check_reset_outputs(input int g);
        check_eq("rst_enb", 32'(enb_w[g]), 0);
        check_eq("rst_valid", 32'(mv_w[g]), 0);
        check_eq("rst_data", 32'(md_w[g]), 0);
        check_eq("rst_count", 32'(rdc_w[g]), 0);
        check_eq("rst_ovf", 32'(ovf_w[g]), 0);
    endtask

    initial begin
        int p0;
        int c0;
        int c1;
        int n;
        rstb_a = '{1'b0, 1'b0};
        mrdy_a = '{1'b0, 1'b0};
        wr_a   = '{0, 0};
        repeat (3) tick();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rstb_a[0] = 1'b1;
        rstb_a[1] = 1'b1;

        // Idle with an empty FIFO
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_enb", 32'(enb_w[0]), 0);
            check_eq("idle_valid", 32'(mv_w[0]), 0);
            check_eq("idle_count", 32'(rdc_w[0]), 0);
        end

        // Full-rate streaming
        mrdy_a[0] = 1'b1;
        preload(0, 64, 8'h00);
        wait_dlv(0, 1, c0);
        wait_dlv(0, 41, c1);
        check_eq("stream_rate", c1 - c0, 40);
        wait_drain(0, 200);
        check_eq("count_64", 32'(rdc_w[0]), 64);

        // Backpressure: only BUF_D pops may be outstanding
        mrdy_a[0] = 1'b0;
        p0 = pops_w[0];
        preload(0, 64, 8'h00);
        repeat (30) tick();
        check_eq("bp_pops", pops_w[0] - p0, 4);
        check_eq("bp_enb", 32'(enb_w[0]), 0);
        check_eq("bp_valid", 32'(mv_w[0]), 1);
        mrdy_a[0] = 1'b1;
        wait_drain(0, 300);
        check_eq("bp_ovf", 32'(ovf_w[0]), 0);
        check_eq("count_128", 32'(rdc_w[0]), 128);

        // Tail single-stepping
        p0 = pops_w[0];
        tail_mode = 1'b1;
        preload(0, 3, 8'hA0);
        wait_drain(0, 100);
        repeat (5) tick();
        check_eq("tail_pops", pops_w[0] - p0, 3);
        check_eq("tail_enb", 32'(enb_w[0]), 0);
        tail_mode = 1'b0;

        // Asynchronous reset mid-stream
        preload(0, 20, 8'h40);
        wait_dlv(0, dlv[0] + 6, c0);
        rstb_a[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        n = wr_a[0] - rd_w[0];
        sb[0].delete();
        for (int i = rd_w[0]; i < wr_a[0]; i++) sb[0].push_back(fmem[0][i & 255]);
        repeat (3) tick();
        rstb_a[0] = 1'b1;
        wait_drain(0, 200);
        check_eq("post_rst_count", 32'(rdc_w[0]), n);

        // Narrow counter wrap, RD_LAT=3
        mrdy_a[1] = 1'b1;
        preload(1, 17, 8'h10);
        wait_drain(1, 200);
        check_eq("wrap_count", 32'(rdc_w[1]), 1);

        // Random backpressure, RD_LAT=3
        preload(1, 60, 8'h80);
        for (int i = 0; i < 300; i++) begin
            mrdy_a[1] = 1'($urandom_range(0, 1));
            tick();
        end
        mrdy_a[1] = 1'b1;
        wait_drain(1, 300);
        check_eq("rand_ovf", 32'(ovf_w[1]), 0);
        check_eq("rand_dlv", dlv[1], 77);
        check_eq("rand_count", 32'(rdc_w[1]), 77 % 16);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
